mr_chips_prog_loader: RTL
=========================

# mr_chips_prog_loader

Program loader for the mr_chips 16-bit CPU: accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words and writes them into the CPU instruction memory from address 0 upward. It holds the CPU in reset while loading and releases it only after a checksum-verified image has been fully written. This is the writer side of the instruction memory that the CPU reads, and it replaces bench-driven reset sequencing for stand-alone runs.

## Interface
- ADDR_W, 8, instruction memory address width; capacity DEPTH = 2**ADDR_W words
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  byte on in_data is valid
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  one-cycle instruction memory write strobe
- imem_addr  output  ADDR_W  write address (word index)
- imem_wdata  output  16  write data
- cpu_reset  output  1  reset to mr_chips, active-high
- load_done  output  1  image loaded and verified, sticky
- load_error  output  1  length or checksum failure, sticky

## Operation
- Stream format: CNT_HI, CNT_LO (16-bit word count N), then N words as HI byte, LO byte, then one checksum byte.
- Checksum: XOR of every preceding byte of the stream (count bytes and all data bytes).
- Transfer occurs on a cycle with in_valid && in_ready; no transfer otherwise, state held.
- States: S_CNT_HI -> S_CNT_LO -> S_DATA_HI <-> S_DATA_LO -> S_CSUM -> S_DONE | S_ERR.
- S_CNT_LO transfer: if N > DEPTH -> S_ERR; if N == 0 -> S_CSUM; else -> S_DATA_HI, word index cleared to 0.
- S_DATA_HI transfer: latch high byte -> S_DATA_LO.
- S_DATA_LO transfer: issue write {hi, lo} at current word index; increment index; if index+1 == N -> S_CSUM else -> S_DATA_HI.
- S_CSUM transfer: byte == running XOR -> S_DONE, otherwise -> S_ERR.
- S_DONE: cpu_reset = 0, load_done = 1, in_ready = 0; held until reset.
- S_ERR: cpu_reset = 1, load_error = 1, in_ready = 0; held until reset.
- Running XOR and word index are 8-bit and 16-bit registers, cleared on reset; word index compared against N at full 16-bit width (no wrap; N == DEPTH fills memory exactly, last address DEPTH-1).
- in_ready = 1 in S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CSUM; 0 elsewhere (combinational from state).

## Timing
- Reset values: state S_CNT_HI, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, load_done 0, load_error 0; in_ready 1 in the first cycle after reset deasserts.
- Reset asserted at any point (including mid-word or in S_DONE) aborts: all state returns to reset values the next edge, cpu_reset re-asserts, partial writes are not undone.
- imem_we, imem_addr, imem_wdata are registered: write strobe asserted exactly one cycle after the S_DATA_LO transfer, for one cycle; addr/wdata valid in that cycle and held afterwards.
- cpu_reset falls and load_done rises one cycle after the accepted checksum transfer; load_error rises one cycle after the failing transfer.
- Full throughput: one byte per cycle; minimum load time 2N+3 cycles.
- The final data write strobe and the checksum transfer may occur in the same cycle; both must take effect.

## Test plan
- Nominal: bytes 00 02 12 34 AB CD 42 back-to-back -> writes 0x1234@0, 0xABCD@1, each one cycle after its LO byte; cpu_reset 0 and load_done 1 one cycle after 0x42; in_ready 0 afterwards.
- Gapped stream: same bytes with in_valid deasserted 3 cycles between each byte -> identical writes and completion, no extra or duplicate strobes.
- Zero length: 00 00 00 -> no imem_we, load_done 1, cpu_reset 0.
- Bad checksum: 00 01 00 10 FF -> write 0x0010@0, then load_error 1, cpu_reset stays 1, in_ready 0, load_done 0.
- Length limits (ADDR_W=8): count 01 01 -> load_error one cycle after second byte, no writes; count 01 00 with 256 words and correct checksum -> last write at address 0xFF, load_done 1.
- Reset mid-load: assert reset after 00 02 12 34 AB -> all outputs at reset values, cpu_reset 1; then full nominal stream -> completes normally.

Source files
------------

// File: rtl/mr_chips_prog_loader.sv
// Byte-stream program loader: builds big-endian words, writes imem from 0, gates CPU reset on a verified XOR checksum.
// Accepts one byte per cycle; write strobe/status are registered one cycle after the accepting edge.
module mr_chips_prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // 17 bits so that a 16-bit count can be compared against DEPTH without wrapping
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] idx;
    logic [7:0]  hi_byte;
    logic [7:0]  csum;
    logic        xfer;
    logic [15:0] n_new;
    logic [15:0] idx_next;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CSUM: in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign xfer     = in_valid && in_ready;
    assign n_new    = {cnt[15:8], in_data};
    assign idx_next = idx + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_CNT_HI;
            cnt        <= '0;
            idx        <= '0;
            hi_byte    <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (xfer) begin
                // The checksum byte itself is excluded from the running XOR
                if (state != S_CSUM)
                    csum <= csum ^ in_data;
                case (state)
                    S_CNT_HI: begin
                        cnt[15:8] <= in_data;
                        state     <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        cnt[7:0] <= in_data;
                        idx      <= '0;
                        if ({1'b0, n_new} > DEPTH) begin
                            state      <= S_ERR;
                            load_error <= 1'b1;
                        end else if (n_new == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                    S_DATA_HI: begin
                        hi_byte <= in_data;
                        state   <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= idx[ADDR_W-1:0];
                        imem_wdata <= {hi_byte, in_data};
                        idx        <= idx_next;
                        state      <= (idx_next == cnt) ? S_CSUM : S_DATA_HI;
                    end
                    S_CSUM: begin
                        if (in_data == csum) begin
                            state     <= S_DONE;
                            cpu_reset <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state      <= S_ERR;
                            load_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
